// File: rtl/not_bubble_pkg.sv
// Shared types and constants for the not_bubble solver.
package not_bubble_pkg;

  localparam int ASSIGN_W   = 4;
  localparam int NUM_ASSIGN = 16;
  localparam logic [ASSIGN_W-1:0] LAST_ASSIGN = 4'd15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/not_bubble_solver_if.sv
// Control and match-stream bundle for not_bubble_solver.
// match_count exists only when NOT_BUBBLE_SOLVER_COUNT_EN is defined.
interface not_bubble_solver_if;
  import not_bubble_pkg::*;

  logic                start;
  logic                target;
  logic                busy;
  logic                m_valid;
  logic                m_ready;
  logic [ASSIGN_W-1:0] m_assign;
  logic                done;
`ifdef NOT_BUBBLE_SOLVER_COUNT_EN
  logic [4:0]          match_count;

  modport master (output start, target, m_ready,
                  input  busy, m_valid, m_assign, done, match_count);
  modport slave  (input  start, target, m_ready,
                  output busy, m_valid, m_assign, done, match_count);
`else
  modport master (output start, target, m_ready,
                  input  busy, m_valid, m_assign, done);
  modport slave  (input  start, target, m_ready,
                  output busy, m_valid, m_assign, done);
`endif

endinterface

// File: rtl/not_bubble_eval.sv
// Combinational evaluator y = ~((~a & ~b) | (c & d)), x = {a,b,c,d}.
// Kept as an explicit NOT/AND/OR tree so structural queries see each gate.
module not_bubble_eval
  import not_bubble_pkg::*;
(
  input  logic [ASSIGN_W-1:0] x_i,
  output logic                y_o
);

  logic not_a;
  logic not_b;
  logic and_ab;
  logic and_cd;
  logic or_all;

  assign not_a  = ~x_i[3];
  assign not_b  = ~x_i[2];
  assign and_ab = not_a & not_b;
  assign and_cd = x_i[1] & x_i[0];
  assign or_all = and_ab | and_cd;
  assign y_o    = ~or_all;

endmodule

// File: rtl/not_bubble_solver.sv
// Enumerates all 16 {a,b,c,d} assignments and streams those whose f matches
// the latched target. Optional match counter: NOT_BUBBLE_SOLVER_COUNT_EN.
module not_bubble_solver
  import not_bubble_pkg::*;
#(
  parameter bit STOP_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  not_bubble_solver_if.slave bus
);

  state_e              state_q, state_d;
  logic [ASSIGN_W-1:0] cnt_q, cnt_d;
  logic [ASSIGN_W-1:0] m_assign_q, m_assign_d;
  logic                target_q, target_d;
  logic                m_valid_q, m_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                f_cnt;
  logic                is_last;
  logic                handshake;

  not_bubble_eval u_eval (
    .x_i (cnt_q),
    .y_o (f_cnt)
  );

  assign is_last   = (cnt_q == LAST_ASSIGN);
  assign handshake = m_valid_q & bus.m_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SEARCH;
      SEARCH:  if (f_cnt == target_q) state_d = EMIT;
               else if (is_last)      state_d = DONE;
      EMIT:    if (handshake) state_d = (STOP_FIRST || is_last) ? DONE : SEARCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    target_d   = target_q;
    m_valid_d  = m_valid_q;
    m_assign_d = m_assign_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        target_d = bus.target;
        cnt_d    = '0;
      end
      SEARCH: if (f_cnt == target_q) begin
        m_assign_d = cnt_q;
        m_valid_d  = 1'b1;
      end else if (!is_last) begin
        cnt_d = cnt_q + ASSIGN_W'(1);
      end
      EMIT: if (handshake) begin
        m_valid_d = 1'b0;
        if (!(STOP_FIRST || is_last)) cnt_d = cnt_q + ASSIGN_W'(1);
      end
      default: ;
    endcase
    // Status flags are decoded from the next state so they register in step with it.
    busy_d = (state_d == SEARCH) || (state_d == EMIT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      target_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_assign_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      target_q   <= target_d;
      m_valid_q  <= m_valid_d;
      m_assign_q <= m_assign_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.m_assign = m_assign_q;
  assign bus.done     = done_q;

`ifdef NOT_BUBBLE_SOLVER_COUNT_EN
  logic [4:0] match_count_q, match_count_d;

  always_comb begin
    match_count_d = match_count_q;
    if (state_q == IDLE && bus.start) match_count_d = '0;
    else if (state_q == EMIT && handshake) match_count_d = match_count_q + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) match_count_q <= '0;
    else     match_count_q <= match_count_d;
  end

  assign bus.match_count = match_count_q;
`endif

endmodule

// File: tb/tb_not_bubble_solver.sv
// Scoreboard bench for not_bubble_solver: expected matches are queued at start
// and popped on each accepted handshake; a STOP_FIRST=1 instance runs alongside.
module tb_not_bubble_solver;
  import not_bubble_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [ASSIGN_W-1:0] exp_q[$];

  not_bubble_solver_if bus_a ();
  not_bubble_solver_if bus_f ();

  not_bubble_solver #(.STOP_FIRST(1'b0)) u_all   (.clk(clk), .rst(rst), .bus(bus_a));
  not_bubble_solver #(.STOP_FIRST(1'b1)) u_first (.clk(clk), .rst(rst), .bus(bus_f));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic ref_f(input logic [3:0] x);
    return ~((~x[3] & ~x[2]) | (x[1] & x[0]));
  endfunction

  task automatic run_search(input logic tgt, input int stall, input bit poke);
    int cyc, first_v, hs, n_exp, stall_left, dones;
    logic [ASSIGN_W-1:0] first_k, got;
    exp_q.delete();
    for (int x = 0; x < NUM_ASSIGN; x++)
      if (ref_f(x[3:0]) == tgt) exp_q.push_back(x[3:0]);
    n_exp      = exp_q.size();
    first_k    = exp_q[0];
    stall_left = stall;
    bus_a.m_ready = (stall == 0);
    @(posedge clk); #1;
    bus_a.start  = 1'b1;
    bus_a.target = tgt;
    @(posedge clk); #1;
    bus_a.start  = 1'b0;
    bus_a.target = ~tgt;
    cyc = 1; first_v = 0; hs = 0; dones = 0;
    while (dones == 0 && cyc < 200) begin
      @(negedge clk);
      if (bus_a.done) begin
        dones++;
        check("busy_at_done", bus_a.busy, 0);
        check("done_cycle", cyc, NUM_ASSIGN + n_exp + 1 + stall);
      end else begin
        if (bus_a.m_valid && first_v == 0) first_v = cyc;
        if (bus_a.m_valid && !bus_a.m_ready) begin
          if (stall_left > 0) begin
            check("hold_assign", bus_a.m_assign, exp_q[0]);
            stall_left--;
          end else begin
            bus_a.m_ready = 1'b1;
          end
        end
        if (bus_a.m_valid && bus_a.m_ready) begin
          hs++;
          if (exp_q.size() == 0) check("sb_extra", bus_a.m_assign, 99);
          else begin
            got = exp_q.pop_front();
            check("m_assign", bus_a.m_assign, got);
          end
        end
        if (poke && cyc == 3) begin
          bus_a.start  = 1'b1;
          bus_a.target = ~tgt;
        end else if (poke && cyc == 4) begin
          bus_a.start = 1'b0;
        end
        @(posedge clk);
        cyc++;
      end
    end
    if (dones == 0) check("done_timeout", 0, 1);
    check("first_valid_cycle", first_v, first_k + 2);
    check("handshake_count", hs, n_exp);
    check("sb_empty", exp_q.size(), 0);
`ifdef NOT_BUBBLE_SOLVER_COUNT_EN
    check("match_count", bus_a.match_count, n_exp);
`endif
    @(negedge clk);
    check("done_one_cycle", bus_a.done, 0);
    check("busy_after_done", bus_a.busy, 0);
`ifdef NOT_BUBBLE_SOLVER_COUNT_EN
    check("match_count_hold", bus_a.match_count, n_exp);
`endif
  endtask

  task automatic run_first;
    int cyc, hs, hs_cyc, done_cyc;
    bus_f.m_ready = 1'b1;
    @(posedge clk); #1;
    bus_f.start  = 1'b1;
    bus_f.target = 1'b1;
    @(posedge clk); #1;
    bus_f.start = 1'b0;
    cyc = 1; hs = 0; hs_cyc = 0; done_cyc = 0;
    while (done_cyc == 0 && cyc < 60) begin
      @(negedge clk);
      if (bus_f.done) begin
        done_cyc = cyc;
        check("sf_busy_at_done", bus_f.busy, 0);
      end else begin
        if (bus_f.m_valid && bus_f.m_ready) begin
          hs++;
          hs_cyc = cyc;
          check("sf_m_assign", bus_f.m_assign, 4);
        end
        @(posedge clk);
        cyc++;
      end
    end
    if (done_cyc == 0) check("sf_done_timeout", 0, 1);
    check("sf_handshakes", hs, 1);
    check("sf_done_after_hs", done_cyc, hs_cyc + 1);
    repeat (3) begin
      @(negedge clk);
      check("sf_idle_busy", bus_f.busy, 0);
      check("sf_idle_valid", bus_f.m_valid, 0);
    end
  endtask

  task automatic reset_in_emit;
    int cyc, dones;
    bus_a.m_ready = 1'b0;
    @(posedge clk); #1;
    bus_a.start  = 1'b1;
    bus_a.target = 1'b0;
    @(posedge clk); #1;
    bus_a.start = 1'b0;
    cyc = 0;
    while (!bus_a.m_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("emit_reached", bus_a.m_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_m_valid", bus_a.m_valid, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_m_assign", bus_a.m_assign, 0);
    check("rst_done", bus_a.done, 0);
`ifdef NOT_BUBBLE_SOLVER_COUNT_EN
    check("rst_match_count", bus_a.match_count, 0);
`endif
    @(posedge clk); #2 rst = 1'b0;
    bus_a.m_ready = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus_a.done) dones++;
    end
    check("no_done_after_rst", dones, 0);
    check("idle_after_rst", bus_a.busy, 0);
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.target = 1'b0; bus_a.m_ready = 1'b0;
    bus_f.start = 1'b0; bus_f.target = 1'b0; bus_f.m_ready = 1'b0;
    #12;
    check("reset_busy", bus_a.busy, 0);
    check("reset_m_valid", bus_a.m_valid, 0);
    check("reset_m_assign", bus_a.m_assign, 0);
    check("reset_done", bus_a.done, 0);
    check("reset_f_valid", bus_f.m_valid, 0);
`ifdef NOT_BUBBLE_SOLVER_COUNT_EN
    check("reset_match_count", bus_a.match_count, 0);
`endif
    #11 rst = 1'b0;

    run_search(1'b1, 0, 1'b0);
    run_search(1'b0, 0, 1'b0);
    run_first();
    run_search(1'b1, 5, 1'b0);
    run_search(1'b1, 0, 1'b1);
    reset_in_emit();
    run_search(1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/not_bubble_solver.md
# not_bubble_solver

Sequential inverse of the `not_bubble` logic-tree fixture. Given a target output value, the block enumerates all 16 input assignments of y = ~((~a & ~b) | (c & d)). It streams every assignment that produces the target over a valid/ready interface. It is a composite fixture with a counter, an FSM and a handshake, sitting beside the combinational logic-tree fixtures for structural-query tests.

## Interface
Parameters:
- `STOP_FIRST`, default 0: 1 = finish after the first accepted match; 0 = emit all matches.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  begin search; sampled only in IDLE.
- `target`  in  1  desired y; latched when `start` is accepted.
- `busy`  out  1  high in SEARCH and EMIT.
- `m_valid`  out  1  match available.
- `m_ready`  in  1  consumer accepts match.
- `m_assign`  out  4  matching assignment {a,b,c,d}; a is bit 3.
- `done`  out  1  one-cycle pulse at end of search.
- `match_count`  out  5  accepted matches this search; present only with `NOT_BUBBLE_SOLVER_COUNT_EN`.

## Operation
- f(x) = ~((~x[3] & ~x[2]) | (x[1] & x[0])), evaluated on the 4-bit candidate counter `cnt`.
- FSM states:
  - IDLE:
    - `start` = 1: `target_q` <= `target`, `cnt` <= 0, go to SEARCH.
  - SEARCH, one candidate per cycle:
    - f(cnt) == `target_q`: `m_assign` <= `cnt`, `m_valid` <= 1, go to EMIT.
    - No match and `cnt` == 15: go to DONE.
    - Otherwise: `cnt` <= `cnt` + 1.
  - EMIT: hold `m_valid` and `m_assign` stable until `m_valid` & `m_ready`. On that handshake:
    - Clear `m_valid`.
    - If `STOP_FIRST` = 1 or `cnt` == 15: go to DONE.
    - Otherwise: `cnt` <= `cnt` + 1, go to SEARCH.
  - DONE: `done` = 1 for this cycle only, then go to IDLE.
- `cnt` never wraps within a search. Reaching 15 ends the scan. There are no arithmetic carries beyond 4 bits.
- `start` is ignored outside IDLE. `target` changes after acceptance have no effect.
- Expected match sets:
  - target = 1: {4, 5, 6, 8, 9, 10, 12, 13, 14} (9 matches).
  - target = 0: {0, 1, 2, 3, 7, 11, 15} (7 matches).

## Timing
- Reset, asynchronous: state = IDLE, `cnt` = 0, `target_q` = 0, `busy` = 0, `m_valid` = 0, `m_assign` = 0, `done` = 0, `match_count` = 0.
- Reset mid-search aborts immediately. There is no `done` pulse, and any pending match is dropped.
- All outputs are registered.
- `start` accepted at edge E: SEARCH evaluates `cnt` = 0 in the cycle after E.
- Match at `cnt` = k with no prior stalls: `m_valid` rises k+2 cycles after the start edge.
- `m_ready` may be held high permanently. Each match then costs exactly one EMIT cycle.
- `m_ready` asserted while `m_valid` = 0 has no effect.
- `done` rises the cycle after the final SEARCH/EMIT cycle. `busy` is low in that same cycle.
- Full scan, target = 1, `m_ready` = 1, `STOP_FIRST` = 0: 16 SEARCH + 9 EMIT cycles. `done` is at cycle 26 after the start edge.

## Configuration
- Macro: `NOT_BUBBLE_SOLVER_COUNT_EN`.
- Defined:
  - `match_count` port exists.
  - It clears when `start` is accepted and increments on each `m_valid` & `m_ready` handshake.
  - It holds its value after DONE until the next `start`.
- Undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Package `not_bubble_pkg` holds:
  - state enum (IDLE, SEARCH, EMIT, DONE);
  - `ASSIGN_W` = 4;
  - `NUM_ASSIGN` = 16;
  - `LAST_ASSIGN` = 15.
- Sub-module `not_bubble_eval`: purely combinational 4-bit → 1-bit evaluator of f. The tree is built from explicit NOT/AND/OR so that structural queries match it.
- Top level holds the FSM, `cnt`, output registers and the optional counter.

## Test plan
- target = 1, `m_ready` = 1, `STOP_FIRST` = 0 → `m_assign` sequence 4, 5, 6, 8, 9, 10, 12, 13, 14. `done` pulses once, with `match_count` = 9 when the macro is defined.
- target = 0, `m_ready` = 1 → sequence 0, 1, 2, 3, 7, 11, 15. After 15 the block goes straight to DONE, and `match_count` = 7.
- `STOP_FIRST` = 1, target = 1 → single match 4. `done` comes 1 cycle after the handshake, and `busy` is low afterwards.
- Backpressure: `m_ready` = 0 for 5 cycles on the first match → `m_valid` and `m_assign` = 4 are held stable. There are no duplicates or skips once ready rises.
- `start` pulsed during SEARCH, with `target` toggled → ignored. The sequence matches the originally latched target.
- `rst` asserted while in EMIT → outputs are 0 asynchronously and `done` never pulses. A new `start` then yields the full correct sequence.
